// File: rtl/axi_aw_rr_arbiter.sv
// Per-slave AW arbiter: round-robin grant, registered AW payload, grant-order FIFO steering the W mux.
// Optional build macro AXI_AW_ARB_QOS_EN: only the highest-AWQOS valid masters compete.
module axi_aw_rr_arbiter #(
   parameter int unsigned NUM_MST       = 4,
   parameter int unsigned ID_WIDTH      = 4,
   parameter int unsigned ADDR_WIDTH    = 32,
   parameter int unsigned MAX_PENDING_W = 4
) (
   input  logic                                        clk_i,
   input  logic                                        rst_ni,
   input  logic [NUM_MST-1:0]                          mst_aw_valid_i,
   output logic [NUM_MST-1:0]                          mst_aw_ready_o,
   input  logic [NUM_MST*ID_WIDTH-1:0]                 mst_aw_id_i,
   input  logic [NUM_MST*ADDR_WIDTH-1:0]               mst_aw_addr_i,
   input  logic [NUM_MST*8-1:0]                        mst_aw_len_i,
   input  logic [NUM_MST*4-1:0]                        mst_aw_qos_i,
   output logic                                        slv_aw_valid_o,
   input  logic                                        slv_aw_ready_i,
   output logic [ID_WIDTH-1:0]                         slv_aw_id_o,
   output logic [ADDR_WIDTH-1:0]                       slv_aw_addr_o,
   output logic [7:0]                                  slv_aw_len_o,
   output logic [((NUM_MST > 1) ? $clog2(NUM_MST) : 1)-1:0] w_sel_o,
   output logic                                        w_sel_valid_o,
   input  logic                                        w_last_hs_i
);

   localparam int unsigned SEL_W = (NUM_MST > 1) ? $clog2(NUM_MST) : 1;
   localparam int unsigned PTR_W = (MAX_PENDING_W > 1) ? $clog2(MAX_PENDING_W) : 1;
   localparam int unsigned CNT_W = $clog2(MAX_PENDING_W + 1);

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } out_state_e;

   out_state_e          state_q;
   logic [SEL_W-1:0]    rr_ptr_q;
   logic [SEL_W-1:0]    fifo_q [MAX_PENDING_W];
   logic [PTR_W-1:0]    wr_ptr_q;
   logic [PTR_W-1:0]    rd_ptr_q;
   logic [CNT_W-1:0]    count_q;

   logic [NUM_MST-1:0]  eligible;
   logic [SEL_W-1:0]    winner;
   logic [SEL_W-1:0]    rr_next;
   logic                found;
   logic                can_accept;
   logic                grant;
   logic                pop;
   int unsigned         idx;
   logic [ID_WIDTH-1:0]   win_id;
   logic [ADDR_WIDTH-1:0] win_addr;
   logic [7:0]            win_len;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(MAX_PENDING_W - 1)) ? '0 : p + PTR_W'(1);
   endfunction

`ifdef AXI_AW_ARB_QOS_EN
   logic [3:0] max_qos;

   // Only masters at the highest requested QoS level enter the round-robin
   always_comb begin
      max_qos  = '0;
      eligible = '0;
      for (int unsigned m = 0; m < NUM_MST; m++) begin
         if (mst_aw_valid_i[m] && (mst_aw_qos_i[m*4 +: 4] > max_qos)) begin
            max_qos = mst_aw_qos_i[m*4 +: 4];
         end
      end
      for (int unsigned m = 0; m < NUM_MST; m++) begin
         eligible[m] = mst_aw_valid_i[m] && (mst_aw_qos_i[m*4 +: 4] == max_qos);
      end
   end
`else
   logic unused_qos;
   assign unused_qos = ^mst_aw_qos_i;
   assign eligible   = mst_aw_valid_i;
`endif

   // First eligible master scanning upward from the pointer, wrapping at NUM_MST
   always_comb begin
      winner = '0;
      found  = 1'b0;
      idx    = 0;
      for (int unsigned i = 0; i < NUM_MST; i++) begin
         idx = int'(rr_ptr_q) + i;
         if (idx >= NUM_MST) begin
            idx = idx - NUM_MST;
         end
         if (!found && eligible[SEL_W'(idx)]) begin
            winner = SEL_W'(idx);
            found  = 1'b1;
         end
      end
   end

   always_comb begin
      win_id   = '0;
      win_addr = '0;
      win_len  = '0;
      for (int unsigned m = 0; m < NUM_MST; m++) begin
         if (SEL_W'(m) == winner) begin
            win_id   = mst_aw_id_i[m*ID_WIDTH +: ID_WIDTH];
            win_addr = mst_aw_addr_i[m*ADDR_WIDTH +: ADDR_WIDTH];
            win_len  = mst_aw_len_i[m*8 +: 8];
         end
      end
   end

   // Full check uses the registered count so a same-cycle pop cannot open a slot
   assign can_accept = ((state_q == EMPTY) || slv_aw_ready_i) && (count_q < CNT_W'(MAX_PENDING_W));
   assign grant      = rst_ni && can_accept && found;
   assign rr_next    = (winner == SEL_W'(NUM_MST - 1)) ? '0 : winner + SEL_W'(1);
   assign pop        = w_last_hs_i && (count_q != '0);

   always_comb begin
      mst_aw_ready_o = '0;
      if (grant) begin
         mst_aw_ready_o[winner] = 1'b1;
      end
   end

   // Output register: payload only reloads on a grant, so it holds while the slave stalls
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q       <= EMPTY;
         rr_ptr_q      <= '0;
         slv_aw_id_o   <= '0;
         slv_aw_addr_o <= '0;
         slv_aw_len_o  <= '0;
      end else begin
         if (grant) begin
            state_q       <= FULL;
            rr_ptr_q      <= rr_next;
            slv_aw_id_o   <= win_id;
            slv_aw_addr_o <= win_addr;
            slv_aw_len_o  <= win_len;
         end else if ((state_q == FULL) && slv_aw_ready_i) begin
            state_q <= EMPTY;
         end
      end
   end

   assign slv_aw_valid_o = (state_q == FULL);

   // Grant-order FIFO; head owns the W channel until its WLAST
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int unsigned i = 0; i < MAX_PENDING_W; i++) begin
            fifo_q[i] <= '0;
         end
      end else begin
         if (grant) begin
            fifo_q[wr_ptr_q] <= winner;
            wr_ptr_q         <= ptr_inc(wr_ptr_q);
         end
         if (pop) begin
            rd_ptr_q <= ptr_inc(rd_ptr_q);
         end
         if (grant && !pop) begin
            count_q <= count_q + CNT_W'(1);
         end else if (!grant && pop) begin
            count_q <= count_q - CNT_W'(1);
         end
      end
   end

   assign w_sel_valid_o = (count_q != '0);
   assign w_sel_o       = (count_q != '0) ? fifo_q[rd_ptr_q] : '0;

`ifndef SYNTHESIS
   w_last_when_empty: assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(w_last_hs_i && (count_q == '0)))
      else $error("w_last_hs_i with no outstanding W burst");
`endif

endmodule

// File: tb/tb_axi_aw_rr_arbiter.sv
// Directed bench for axi_aw_rr_arbiter: reset, round-robin order, FIFO gating, backpressure, W ordering.
module tb_axi_aw_rr_arbiter;

   localparam int unsigned NUM_MST       = 4;
   localparam int unsigned ID_WIDTH      = 4;
   localparam int unsigned ADDR_WIDTH    = 32;
   localparam int unsigned MAX_PENDING_W = 4;

   logic                          clk_i = 1'b0;
   logic                          rst_ni;
   logic [NUM_MST-1:0]            mst_aw_valid;
   logic [NUM_MST-1:0]            mst_aw_ready;
   logic [NUM_MST*ID_WIDTH-1:0]   mst_aw_id;
   logic [NUM_MST*ADDR_WIDTH-1:0] mst_aw_addr;
   logic [NUM_MST*8-1:0]          mst_aw_len;
   logic [NUM_MST*4-1:0]          mst_aw_qos;
   logic                          slv_aw_valid;
   logic                          slv_aw_ready;
   logic [ID_WIDTH-1:0]           slv_aw_id;
   logic [ADDR_WIDTH-1:0]         slv_aw_addr;
   logic [7:0]                    slv_aw_len;
   logic [1:0]                    w_sel;
   logic                          w_sel_valid;
   logic                          w_last_hs;

   int n_checks = 0;
   int n_errors = 0;

   axi_aw_rr_arbiter #(
      .NUM_MST      (NUM_MST),
      .ID_WIDTH     (ID_WIDTH),
      .ADDR_WIDTH   (ADDR_WIDTH),
      .MAX_PENDING_W(MAX_PENDING_W)
   ) dut (
      .clk_i          (clk_i),
      .rst_ni         (rst_ni),
      .mst_aw_valid_i (mst_aw_valid),
      .mst_aw_ready_o (mst_aw_ready),
      .mst_aw_id_i    (mst_aw_id),
      .mst_aw_addr_i  (mst_aw_addr),
      .mst_aw_len_i   (mst_aw_len),
      .mst_aw_qos_i   (mst_aw_qos),
      .slv_aw_valid_o (slv_aw_valid),
      .slv_aw_ready_i (slv_aw_ready),
      .slv_aw_id_o    (slv_aw_id),
      .slv_aw_addr_o  (slv_aw_addr),
      .slv_aw_len_o   (slv_aw_len),
      .w_sel_o        (w_sel),
      .w_sel_valid_o  (w_sel_valid),
      .w_last_hs_i    (w_last_hs)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic check_slv(input string tag, input logic v, input logic [3:0] id,
                            input logic [31:0] addr, input logic [7:0] len);
      check({tag, "_valid"}, 64'(slv_aw_valid), 64'(v));
      check({tag, "_payload"}, 64'({slv_aw_id, slv_aw_addr, slv_aw_len}), 64'({id, addr, len}));
   endtask

   task automatic tick;
      @(posedge clk_i);
      #1;
   endtask

   task automatic set_mst(input int m, input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len);
      mst_aw_id[m*ID_WIDTH +: ID_WIDTH]       = id;
      mst_aw_addr[m*ADDR_WIDTH +: ADDR_WIDTH] = addr;
      mst_aw_len[m*8 +: 8]                    = len;
   endtask

   initial begin
      rst_ni       = 1'b0;
      mst_aw_valid = 4'hF;
      mst_aw_qos   = '0;
      slv_aw_ready = 1'b0;
      w_last_hs    = 1'b0;
      for (int m = 0; m < 4; m++) begin
         set_mst(m, 4'(m + 1), 32'((m + 1) * 256), 8'(m));
      end

      // Reset with every master requesting
      repeat (2) tick;
      #1;
      check("rst_ready", 64'(mst_aw_ready), 64'h0);
      check_slv("rst_slv", 1'b0, 4'h0, 32'h0, 8'h0);
      check("rst_wsel_valid", 64'(w_sel_valid), 64'h0);
      check("rst_wsel", 64'(w_sel), 64'h0);

      // Release: round-robin 0,1,2,3 then FIFO full
      rst_ni       = 1'b1;
      slv_aw_ready = 1'b1;
      #1;
      check("first_grant", 64'(mst_aw_ready), 64'h1);
      tick;
      check_slv("aw_m0", 1'b1, 4'h1, 32'h100, 8'h0);
      check("wsel_after_m0", 64'({w_sel_valid, w_sel}), 64'({1'b1, 2'd0}));
      check("grant_m1", 64'(mst_aw_ready), 64'h2);
      tick;
      check_slv("aw_m1", 1'b1, 4'h2, 32'h200, 8'h1);
      check("grant_m2", 64'(mst_aw_ready), 64'h4);
      tick;
      check_slv("aw_m2", 1'b1, 4'h3, 32'h300, 8'h2);
      check("grant_m3", 64'(mst_aw_ready), 64'h8);
      tick;
      check_slv("aw_m3", 1'b1, 4'h4, 32'h400, 8'h3);
      check("full_gate", 64'(mst_aw_ready), 64'h0);
      tick;
      check("drained_slv_valid", 64'(slv_aw_valid), 64'h0);
      check("full_gate_hold", 64'(mst_aw_ready), 64'h0);

      // Full FIFO with same-cycle pop: no grant until the next cycle
      mst_aw_valid = 4'b0001;
      w_last_hs    = 1'b1;
      #1;
      check("full_pop_no_grant", 64'(mst_aw_ready), 64'h0);
      check("full_pop_head", 64'(w_sel), 64'd0);
      tick;
      w_last_hs = 1'b0;
      #1;
      check("after_pop_head", 64'(w_sel), 64'd1);
      check("after_pop_grant", 64'(mst_aw_ready), 64'h1);
      tick;
      check_slv("aw_m0_again", 1'b1, 4'h1, 32'h100, 8'h0);
      check("count_still_full", 64'(mst_aw_ready), 64'h0);

      // Drain the FIFO in grant order 1,2,3,0
      mst_aw_valid = 4'b0000;
      w_last_hs    = 1'b1;
      #1;
      check("drain_head1", 64'({w_sel_valid, w_sel}), 64'({1'b1, 2'd1}));
      tick;
      check("drain_head2", 64'({w_sel_valid, w_sel}), 64'({1'b1, 2'd2}));
      tick;
      check("drain_head3", 64'({w_sel_valid, w_sel}), 64'({1'b1, 2'd3}));
      tick;
      check("drain_head0", 64'({w_sel_valid, w_sel}), 64'({1'b1, 2'd0}));
      tick;
      check("drain_empty", 64'({w_sel_valid, w_sel}), 64'h0);
      w_last_hs = 1'b0;

      // W ordering: pointer at 1, masters 1 and 3 requesting
      mst_aw_valid = 4'b1010;
      #1;
      check("word_grant_m1", 64'(mst_aw_ready), 64'h2);
      tick;
      check("word_grant_m3", 64'(mst_aw_ready), 64'h8);
      tick;
      mst_aw_valid = 4'b0000;
      #1;
      check("word_sel1", 64'({w_sel_valid, w_sel}), 64'({1'b1, 2'd1}));
      tick;
      check("word_sel1_hold", 64'({w_sel_valid, w_sel}), 64'({1'b1, 2'd1}));
      w_last_hs = 1'b1;
      tick;
      check("word_sel3", 64'({w_sel_valid, w_sel}), 64'({1'b1, 2'd3}));
      tick;
      check("word_empty", 64'({w_sel_valid, w_sel}), 64'h0);
      w_last_hs = 1'b0;

      // Slave backpressure on master 2 payload
      slv_aw_ready = 1'b0;
      set_mst(2, 4'h5, 32'h1000, 8'd3);
      mst_aw_valid = 4'b0100;
      #1;
      check("bp_grant_m2", 64'(mst_aw_ready), 64'h4);
      tick;
      mst_aw_valid = 4'b0101;
      #1;
      for (int c = 0; c < 5; c++) begin
         check_slv("bp_hold", 1'b1, 4'h5, 32'h1000, 8'd3);
         check("bp_no_ready", 64'(mst_aw_ready), 64'h0);
         tick;
      end
      slv_aw_ready = 1'b1;
      #1;
      check("bp_release_grant_m0", 64'(mst_aw_ready), 64'h1);
      tick;
      mst_aw_valid = 4'b0000;
      #1;
      check_slv("bp_next_m0", 1'b1, 4'h1, 32'h100, 8'h0);
      w_last_hs = 1'b1;
      #1;
      check("bp_sel2", 64'({w_sel_valid, w_sel}), 64'({1'b1, 2'd2}));
      tick;
      check("bp_sel0", 64'({w_sel_valid, w_sel}), 64'({1'b1, 2'd0}));
      tick;
      check("bp_empty", 64'({w_sel_valid, w_sel}), 64'h0);
      w_last_hs = 1'b0;

      // Reset asserted mid-burst discards everything immediately
      mst_aw_valid = 4'b0001;
      tick;
      mst_aw_valid = 4'b0000;
      #2;
      rst_ni = 1'b0;
      #1;
      check_slv("midrst_slv", 1'b0, 4'h0, 32'h0, 8'h0);
      check("midrst_wsel", 64'({w_sel_valid, w_sel}), 64'h0);
      check("midrst_ready", 64'(mst_aw_ready), 64'h0);
      tick;
      rst_ni = 1'b1;

`ifdef AXI_AW_ARB_QOS_EN
      // QoS: move pointer to 2 via a lone master 1 grant, then contend
      mst_aw_valid = 4'b0010;
      #1;
      check("qos_setup_m1", 64'(mst_aw_ready), 64'h2);
      tick;
      mst_aw_valid = 4'b0111;
      mst_aw_qos   = {4'd0, 4'd7, 4'd7, 4'd2};
      #1;
      check("qos_m2_wins", 64'(mst_aw_ready), 64'h4);
      tick;
      check("qos_m1_next", 64'(mst_aw_ready), 64'h2);
      tick;
      mst_aw_valid = 4'b0001;
      #1;
      check("qos_m0_last", 64'(mst_aw_ready), 64'h1);
      tick;
      mst_aw_valid = 4'b0000;
`endif

      tick;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
